avalon_mem_responder: RTL and testbench



---
 rtl/avalon_mem_responder.sv | 128 ++++++++++++
 tb/tb_avalon_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory-side responder: word-organised RAM window with configurable wait states,
// byte-enabled writes, and sticky flags for initiator misuse and out-of-window accesses.
module avalon_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        proto_err,
  output logic        oob_err
);

  localparam int          AW           = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  COUNT_INIT   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [3:0]    count;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_wr;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          single_req;
  logic          both_req;
  logic          any_req;
  logic [31:0]   acc_addr;
  logic          acc_wr;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          enter_done;
  logic          req_changed;

  assign any_req    = read | write;
  assign both_req   = read & write;
  assign single_req = read ^ write;

  // Simultaneous read+write in IDLE is a void request, so it must not stall the initiator.
  assign waitrequest = any_req && (state != DONE) && !(state == IDLE && both_req);

  // In IDLE the live bus is decoded so a zero-wait access can complete on its first edge.
  assign acc_addr = (state == IDLE) ? address : lat_addr;
  assign acc_wr   = (state == IDLE) ? write   : lat_wr;
  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = offset < WINDOW_BYTES;
  assign idx      = offset[AW+1:2];

  assign enter_done = (state == IDLE && single_req && WAIT_CYCLES == 0) ||
                      (state == WAIT && any_req && count == 4'd0);

  assign req_changed = (address != lat_addr) || (write != lat_wr) || (read == lat_wr) ||
                       (lat_wr && writedata != lat_wdata);

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      lat_wr    <= 1'b0;
      readdata  <= 32'd0;
      proto_err <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (both_req) begin
            proto_err <= 1'b1;
          end else if (single_req) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_wr    <= write;
            if (address[1:0] != 2'b00) proto_err <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              count <= COUNT_INIT;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          if (!any_req) begin
            state     <= IDLE;
            proto_err <= 1'b1;
          end else begin
            if (req_changed) proto_err <= 1'b1;
            if (count == 4'd0) state <= DONE;
            else               count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_done && !acc_wr) readdata <= in_range ? mem[idx] : 32'd0;
      if (enter_done && !in_range) oob_err <= 1'b1;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its contents
  // across reset; a write is gated by state, so an async reset in DONE cancels it.
  always_ff @(posedge clk) begin
    if (state == DONE && lat_wr && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) mem[idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder: a 2-wait-state instance and a zero-wait instance,
// checked against a byte-lane memory model held in associative arrays.
module tb_avalon_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] address = '0, writedata = '0, readdata;
  logic        read = 1'b0, write = 1'b0, waitrequest, proto_err, oob_err;
  logic [3:0]  byteenable = '0;

  logic [31:0] z_address = '0, z_writedata = '0, z_readdata;
  logic        z_read = 1'b0, z_write = 1'b0, z_waitrequest, z_proto_err, z_oob_err;
  logic [3:0]  z_byteenable = '0;

  avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .proto_err(proto_err), .oob_err(oob_err)
  );

  avalon_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .address(z_address), .read(z_read), .write(z_write),
    .writedata(z_writedata), .byteenable(z_byteenable), .waitrequest(z_waitrequest),
    .readdata(z_readdata), .proto_err(z_proto_err), .oob_err(z_oob_err)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_z_q[$];
  logic [31:0] model[int];
  logic [31:0] model_z[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference memory: byte address -> word, zero outside the window.
  function automatic logic [31:0] ref_read(input bit sel, input logic [31:0] addr);
    logic [31:0] off;
    int          w;
    off = addr - BASE;
    if (off >= 32'(4 * DEPTH)) return 32'd0;
    w = int'(off / 4);
    if (sel) return model_z.exists(w) ? model_z[w] : 32'd0;
    return model.exists(w) ? model[w] : 32'd0;
  endfunction

  task automatic ref_write(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    logic [31:0] off, word;
    int          w;
    off = addr - BASE;
    if (off >= 32'(4 * DEPTH)) return;
    w = int'(off / 4);
    word = ref_read(sel, addr);
    for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = data[8*b +: 8];
    if (sel) model_z[w] = word;
    else     model[w] = word;
  endtask

  // One complete handshake; returns the cycle (1-based) in which waitrequest went low.
  task automatic access(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output int cycles);
    if (wr) ref_write(sel, addr, data, be);
    else if (sel) sb_z_q.push_back(ref_read(sel, addr));
    else sb_q.push_back(ref_read(sel, addr));
    @(posedge clk); #1;
    if (sel) begin
      z_address = addr; z_read = !wr; z_write = wr; z_writedata = data; z_byteenable = be;
    end else begin
      address = addr; read = !wr; write = wr; writedata = data; byteenable = be;
    end
    cycles = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (!(sel ? z_waitrequest : waitrequest)) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: waitrequest still high after 50 cycles at %h", addr);
    end
    @(posedge clk); #1;
    if (sel) begin z_read = 1'b0; z_write = 1'b0; end
    else begin read = 1'b0; write = 1'b0; end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pops the expected word whenever a read completes on either instance.
  always @(negedge clk) begin
    if (reset_n && read && !write && !waitrequest) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_main: unexpected read completion, readdata %h", readdata);
      end else check("sb_main_rd", readdata, sb_q.pop_front());
    end
    if (reset_n && z_read && !z_write && !z_waitrequest) begin
      if (sb_z_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_zero: unexpected read completion, readdata %h", z_readdata);
      end else check("sb_zero_rd", z_readdata, sb_z_q.pop_front());
    end
  end

  initial begin
    int cyc;
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          wr;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_waitrequest", 32'(waitrequest), 32'd0);
      check("idle_readdata", readdata, 32'd0);
      check("idle_flags", {30'd0, proto_err, oob_err}, 32'd0);
    end
    check("idle_zero_flags", {30'd0, z_proto_err, z_oob_err}, 32'd0);

    access(0, 1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, cyc);
    check("wr_latency", 32'(cyc), 32'd4);
    access(0, 0, 32'hBFC00010, 32'h0, 4'hF, cyc);
    check("rd_latency", 32'(cyc), 32'd4);
    @(negedge clk);
    check("rd_hold", readdata, 32'hDEADBEEF);

    access(0, 1, 32'hBFC00010, 32'h00001234, 4'b0011, cyc);
    access(0, 0, 32'hBFC00010, 32'h0, 4'h0, cyc);
    check("partial_write", readdata, 32'hDEAD1234);

    access(0, 1, 32'hBFC00FFC, 32'hA5A5C3C3, 4'hF, cyc);
    access(0, 1, 32'hBFC00000, 32'h11111111, 4'hF, cyc);
    access(0, 0, 32'hBFC00FFC, 32'h0, 4'hF, cyc);

    for (int i = 0; i < 16; i++)
      access(0, 1, 32'hBFC00100 + 32'(4 * i), $urandom, 4'hF, cyc);
    for (int i = 0; i < 60; i++) begin
      a  = 32'hBFC00100 + 32'(4 * $urandom_range(0, 15));
      wr = 1'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      access(0, wr, a, d, be, cyc);
      check("rand_latency", 32'(cyc), 32'd4);
    end
    check("clean_flags", {30'd0, proto_err, oob_err}, 32'd0);

    access(0, 0, 32'h00000000, 32'h0, 4'hF, cyc);
    check("oob_latency", 32'(cyc), 32'd4);
    check("oob_readdata", readdata, 32'h0);
    check("oob_err_set", 32'(oob_err), 32'd1);
    check("oob_no_proto", 32'(proto_err), 32'd0);
    access(0, 1, 32'hBFC01000, 32'hFFFFFFFF, 4'hF, cyc);
    access(0, 0, 32'hBFC01000, 32'h0, 4'hF, cyc);
    access(0, 0, 32'hBFC00000, 32'h0, 4'hF, cyc);
    check("oob_write_dropped", readdata, 32'h11111111);

    access(0, 0, 32'hBFC00012, 32'h0, 4'hF, cyc);
    check("misaligned_proto", 32'(proto_err), 32'd1);

    pulse_reset();
    @(negedge clk);
    check("reset_clears_flags", {30'd0, proto_err, oob_err}, 32'd0);

    @(posedge clk); #1;
    address = 32'hBFC00010; writedata = 32'h0; byteenable = 4'hF; read = 1'b1; write = 1'b1;
    @(negedge clk);
    check("both_waitrequest", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check("both_proto", 32'(proto_err), 32'd1);
    access(0, 0, 32'hBFC00010, 32'h0, 4'hF, cyc);
    check("both_ram_unchanged", readdata, 32'hDEAD1234);

    pulse_reset();
    @(posedge clk); #1;
    address = 32'hBFC00010; writedata = 32'hCAFEF00D; byteenable = 4'hF; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_proto", 32'(proto_err), 32'd1);
    access(0, 0, 32'hBFC00010, 32'h0, 4'hF, cyc);
    check("abort_recover_latency", 32'(cyc), 32'd4);

    @(posedge clk); #1;
    address = 32'hBFC00010; writedata = 32'h0BADF00D; byteenable = 4'hF; write = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check("rst_wait_flags", {30'd0, proto_err, oob_err}, 32'd0);
    check("rst_wait_readdata", readdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    access(0, 0, 32'hBFC00010, 32'h0, 4'hF, cyc);
    check("rst_wait_latency", 32'(cyc), 32'd4);
    check("rst_wait_word", readdata, 32'hDEAD1234);
    check("rst_wait_proto", 32'(proto_err), 32'd0);

    access(1, 1, 32'hBFC00020, 32'h12345678, 4'hF, cyc);
    check("zero_wr_latency", 32'(cyc), 32'd2);
    access(1, 0, 32'hBFC00020, 32'h0, 4'hF, cyc);
    check("zero_rd_latency", 32'(cyc), 32'd2);
    check("zero_rd_data", z_readdata, 32'h12345678);
    for (int i = 0; i < 8; i++) begin
      a = 32'hBFC00040 + 32'(4 * $urandom_range(0, 3));
      access(1, 1, a, $urandom, 4'($urandom), cyc);
      access(1, 0, a, 32'h0, 4'hF, cyc);
    end

    repeat (2) @(negedge clk);
    check("sb_main_drained", 32'(sb_q.size()), 32'd0);
    check("sb_zero_drained", 32'(sb_z_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
